// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the hardwired control unit:
//   - 5-bit opcode values decoded from IR[31:27]
//   - IR field bit positions (op, Ra, Rb, Rc)
//   - 4-bit sequencer state encoding (RST = 0)
//   - instruction class enumeration and the opcode -> class helper
// -----------------------------------------------------------------------------
package cpu_defs;

    // Opcode field values
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // IR field bit positions
    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;

    // Sequencer states; RST must be all-zeros so the async reset lands there
    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

    // Instruction classes that select a step sequence
    typedef enum logic [2:0] {
        CLS_BIN    = 3'd0,
        CLS_MULDIV = 3'd1,
        CLS_UNARY  = 3'd2,
        CLS_NOP    = 3'd3,
        CLS_HALT   = 3'd4
    } op_class_t;

    // Map an opcode onto its class; anything unrecognised runs as a NOP
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  cls = CLS_BIN;
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                 cls = CLS_UNARY;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_reg_decoder.sv
// -----------------------------------------------------------------------------
// reg_decoder
// 4-to-N one-hot decoder with enable. Output is all-zero when en_i is low,
// otherwise exactly bit sel_i is set (if sel_i < NOUT).
// Ports:
//   en_i      in  1     decoder enable
//   sel_i     in  4     register index
//   onehot_o  out NOUT  one-hot select vector
// -----------------------------------------------------------------------------
module reg_decoder #(
    parameter int NOUT = 16
) (
    input  logic            en_i,
    input  logic [3:0]      sel_i,
    output logic [NOUT-1:0] onehot_o
);

    // Each output bit compares the index against its own position
    for (genvar g = 0; g < NOUT; g++) begin : g_bit
        assign onehot_o[g] = en_i & (sel_i == 4'(g));
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
// Hardwired control unit. Fetches an instruction (T0..T2), then steps the
// datapath through T3..T6 according to the opcode class in IR[31:27].
// All outputs are a Moore decode of the state register (plus the IR fields
// from T3 on), so pulling clear low zeroes them within the same cycle.
// Ports:
//   clock       in   1      system clock, rising edge
//   clear       in   1      asynchronous reset, active-low
//   ir          in   32     current IR contents
//   mem_ready   in   1      memory read data valid
//   Rin / Rout  out  NREGS  one-hot register load enables / bus drivers
//   PCout .. LOin out 1     datapath strobes
//   opcode      out  OPW    ALU operation select (NOP code outside T4)
//   run         out  1      high while executing, low in RST and after HALT
//   instr_done  out  1      pulse in the final state of each instruction
// -----------------------------------------------------------------------------
module ctrl_sequencer
    import cpu_defs::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             incPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             read,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             ZLowOut,
    output logic             ZHighOut,
    output logic             HIin,
    output logic             LOin,
    output logic [OPW-1:0]   opcode,
    output logic             run,
    output logic             instr_done
);

    state_t     state_q;
    state_t     state_d;

    logic [4:0] op_s;
    logic [3:0] ra_s;
    logic [3:0] rb_s;
    logic [3:0] rc_s;
    op_class_t  cls_s;

    logic       rin_en_s;
    logic       rout_en_s;
    logic [3:0] rout_sel_s;

    // Low IR bits hold immediates for other instruction formats
    logic       unused_ir_s;
    assign unused_ir_s = ^ir[IR_RC_LO-1:0];

    // IR field extraction; only meaningful once IR is loaded (T3 onward)
    assign op_s  = ir[IR_OP_HI:IR_OP_LO];
    assign ra_s  = ir[IR_RA_HI:IR_RA_LO];
    assign rb_s  = ir[IR_RB_HI:IR_RB_LO];
    assign rc_s  = ir[IR_RC_HI:IR_RC_LO];
    assign cls_s = classify(op_s);

    // Destination register write enable (always Ra)
    reg_decoder #(.NOUT(NREGS)) u_rin_dec (
        .en_i     (rin_en_s),
        .sel_i    (ra_s),
        .onehot_o (Rin)
    );

    // Bus driver select (Rb or Rc depending on step)
    reg_decoder #(.NOUT(NREGS)) u_rout_dec (
        .en_i     (rout_en_s),
        .sel_i    (rout_sel_s),
        .onehot_o (Rout)
    );

    // State register; clear forces RST immediately
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        rin_en_s   = 1'b0;
        rout_en_s  = 1'b0;
        rout_sel_s = rb_s;
        PCout      = 1'b0;
        PCin       = 1'b0;
        incPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        read       = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        ZLowOut    = 1'b0;
        ZHighOut   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        opcode     = OPW'(OP_NOP);
        run        = 1'b1;
        instr_done = 1'b0;

        case (state_q)
            ST_RST: begin
                run     = 1'b0;
                opcode  = {OPW{1'b0}};
                state_d = ST_T0;
            end
            ST_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                incPC   = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                // Hold the read until memory signals valid data; no timeout
                read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) begin
                    state_d = ST_T2;
                end else begin
                    state_d = ST_T1;
                end
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                case (cls_s)
                    CLS_BIN, CLS_MULDIV: begin
                        rout_en_s  = 1'b1;
                        rout_sel_s = rb_s;
                        Yin        = 1'b1;
                        state_d    = ST_T4;
                    end
                    CLS_UNARY: begin
                        state_d = ST_T4;
                    end
                    CLS_HALT: begin
                        instr_done = 1'b1;
                        state_d    = ST_HALTED;
                    end
                    default: begin
                        // NOP and illegal opcodes retire here
                        instr_done = 1'b1;
                        state_d    = ST_T0;
                    end
                endcase
            end
            ST_T4: begin
                case (cls_s)
                    CLS_BIN, CLS_MULDIV: begin
                        rout_en_s  = 1'b1;
                        rout_sel_s = rc_s;
                        Zin        = 1'b1;
                        opcode     = OPW'(op_s);
                        state_d    = ST_T5;
                    end
                    CLS_UNARY: begin
                        // Single operand comes from Rb
                        rout_en_s  = 1'b1;
                        rout_sel_s = rb_s;
                        Zin        = 1'b1;
                        opcode     = OPW'(op_s);
                        state_d    = ST_T5;
                    end
                    default: begin
                        // Not reachable for a stable IR; recover to fetch
                        state_d = ST_T0;
                    end
                endcase
            end
            ST_T5: begin
                case (cls_s)
                    CLS_MULDIV: begin
                        ZLowOut = 1'b1;
                        LOin    = 1'b1;
                        state_d = ST_T6;
                    end
                    CLS_BIN, CLS_UNARY: begin
                        ZLowOut    = 1'b1;
                        rin_en_s   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = ST_T0;
                    end
                    default: begin
                        state_d = ST_T0;
                    end
                endcase
            end
            ST_T6: begin
                ZHighOut   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_T0;
            end
            ST_HALTED: begin
                // Parked until clear is asserted
                run     = 1'b0;
                opcode  = {OPW{1'b0}};
                state_d = ST_HALTED;
            end
            default: begin
                run     = 1'b0;
                opcode  = {OPW{1'b0}};
                state_d = ST_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for ctrl_sequencer. Each instruction is expanded into a per-cycle list
// of {inputs to drive, expected outputs}, pushed onto a queue and popped one
// entry per cycle; outputs are compared on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ctrl_sequencer;

    localparam int PH_HALTED = 8;
    localparam int PH_RST    = 9;

    localparam int K_BIN  = 0;
    localparam int K_MD   = 1;
    localparam int K_UN   = 2;
    localparam int K_NOP  = 3;
    localparam int K_HALT = 4;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        mem_ready = 1'b0;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, incPC, MARin, MDRin, read, MDRout, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0]  opcode;
    logic        run, instr_done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcout, pcin, incpc, marin, mdrin, rd, mdrout, irin;
        logic yin, zin, zlow, zhigh, hiin, loin;
        logic [4:0]  opc;
        logic run;
        logic done;
    } outs_t;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        int          phase;
        outs_t       exp;
    } step_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
    } vec_t;

    step_t q[$];
    vec_t  vec[16];

    ctrl_sequencer #(.NREGS(16), .OPW(5)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin),
        .MDRin(MDRin), .read(read), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .HIin(HIin), .LOin(LOin), .opcode(opcode), .run(run),
        .instr_done(instr_done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] r);
        logic [15:0] v;
        v = 16'h0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic int kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: return K_BIN;
            5'b01110, 5'b01111:                     return K_MD;
            5'b10000, 5'b10001:                     return K_UN;
            5'b11011:                               return K_HALT;
            default:                                return K_NOP;
        endcase
    endfunction

    // Expected outputs for timing step t of instruction instr
    function automatic outs_t exp_for(input int t, input logic [31:0] instr);
        outs_t o;
        int k;
        o = '0;
        k = kind(instr[31:27]);
        if (t == PH_HALTED || t == PH_RST) return o;
        o.run = 1'b1;
        o.opc = 5'b11010;
        case (t)
            0: begin o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; end
            1: begin o.rd = 1'b1; o.mdrin = 1'b1; end
            2: begin o.mdrout = 1'b1; o.irin = 1'b1; end
            3: begin
                if (k == K_BIN || k == K_MD) begin
                    o.rout = oh(instr[22:19]);
                    o.yin  = 1'b1;
                end
                if (k == K_NOP || k == K_HALT) o.done = 1'b1;
            end
            4: begin
                o.zin  = 1'b1;
                o.opc  = instr[31:27];
                o.rout = (k == K_UN) ? oh(instr[22:19]) : oh(instr[18:15]);
            end
            5: begin
                o.zlow = 1'b1;
                if (k == K_MD) o.loin = 1'b1;
                else begin o.rin = oh(instr[26:23]); o.done = 1'b1; end
            end
            6: begin o.zhigh = 1'b1; o.hiin = 1'b1; o.done = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input int t, input logic [31:0] drv_ir, input logic mr,
                        input logic [31:0] instr);
        step_t s;
        s.ir = drv_ir;
        s.mr = mr;
        s.phase = t;
        s.exp = exp_for(t, instr);
        q.push_back(s);
    endtask

    // Expand one instruction into its cycle list; IR holds junk until T3
    task automatic gen_instr(input logic [31:0] instr, input int waits, input int last_t);
        int k;
        k = kind(instr[31:27]);
        push(0, $urandom, 1'($urandom_range(0, 1)), instr);
        for (int w = 0; w <= waits; w++) push(1, $urandom, (w == waits), instr);
        push(2, $urandom, 1'($urandom_range(0, 1)), instr);
        push(3, instr, 1'($urandom_range(0, 1)), instr);
        if (k == K_NOP || k == K_HALT || last_t < 4) return;
        push(4, instr, 1'($urandom_range(0, 1)), instr);
        if (last_t < 5) return;
        push(5, instr, 1'($urandom_range(0, 1)), instr);
        if (k == K_MD) push(6, instr, 1'($urandom_range(0, 1)), instr);
    endtask

    function automatic outs_t actual();
        outs_t a;
        a = {Rin, Rout, PCout, PCin, incPC, MARin, MDRin, read, MDRout, IRin,
             Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, opcode, run, instr_done};
        return a;
    endfunction

    task automatic check_outs(input outs_t e, input int phase, input string name);
        outs_t a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s phase=%0d ir=%h got=%h expected=%h", name, phase, ir, a, e);
        end
    endtask

    task automatic check_bus();
        int n;
        n = int'(PCout) + int'(MDRout) + int'(ZLowOut) + int'(ZHighOut) + $countones(Rout);
        checks++;
        if (n > 1 || $countones(Rin) > 1) begin
            errors++;
            $display("FAIL bus_drivers got=%0d rin_bits=%0d required<=1", n, $countones(Rin));
        end
    endtask

    // Apply one queued cycle per falling edge and compare
    task automatic run_queue(input string name);
        step_t s;
        while (q.size() > 0) begin
            @(negedge clock);
            s = q.pop_front();
            ir = s.ir;
            mem_ready = s.mr;
            #1;
            check_outs(s.exp, s.phase, name);
            check_bus();
        end
    endtask

    initial begin
        outs_t zero_o;
        zero_o = '0;

        vec[0]  = '{mk(5'b00011, 4'd1,  4'd2,  4'd3),  0};  // ADD
        vec[1]  = '{mk(5'b00100, 4'd15, 4'd14, 4'd13), 0};  // SUB
        vec[2]  = '{mk(5'b00101, 4'd0,  4'd0,  4'd0),  0};  // SHR R0,R0,R0
        vec[3]  = '{mk(5'b00110, 4'd7,  4'd8,  4'd9),  1};  // SHL
        vec[4]  = '{mk(5'b00111, 4'd4,  4'd3,  4'd7),  0};  // ROR R4,R3,R7
        vec[5]  = '{mk(5'b01000, 4'd10, 4'd11, 4'd12), 2};  // ROL
        vec[6]  = '{mk(5'b01001, 4'd5,  4'd5,  4'd5),  0};  // AND
        vec[7]  = '{mk(5'b01010, 4'd12, 4'd1,  4'd15), 0};  // OR
        vec[8]  = '{mk(5'b01110, 4'd0,  4'd2,  4'd5),  3};  // MUL R2,R5
        vec[9]  = '{mk(5'b01111, 4'd9,  4'd15, 4'd0),  0};  // DIV
        vec[10] = '{32'h80C80000,                      0};  // NEG R1,R9
        vec[11] = '{mk(5'b10001, 4'd14, 4'd6,  4'd3),  1};  // NOT
        vec[12] = '{mk(5'b11010, 4'd3,  4'd4,  4'd5),  0};  // NOP
        vec[13] = '{mk(5'b00000, 4'd6,  4'd7,  4'd8),  0};  // illegal
        vec[14] = '{mk(5'b11111, 4'd1,  4'd1,  4'd1),  2};  // illegal
        vec[15] = '{mk(5'b01011, 4'd2,  4'd3,  4'd4),  0};  // illegal

        // Reset held for three cycles with arbitrary inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            ir = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check_outs(zero_o, PH_RST, "reset");
        end
        clear = 1'b1;

        for (int i = 0; i < 16; i++) begin
            gen_instr(vec[i].ir, vec[i].waits, 6);
            run_queue("vector");
        end

        // Clear mid-T4 of an ADD: outputs drop at once, no Rin write follows
        gen_instr(mk(5'b00011, 4'd6, 4'd2, 4'd11), 0, 4);
        run_queue("add_to_t4");
        #2;
        clear = 1'b0;
        #1;
        check_outs(zero_o, PH_RST, "clear_async");
        @(negedge clock);
        #1;
        check_outs(zero_o, PH_RST, "clear_held");
        clear = 1'b1;
        gen_instr(mk(5'b10001, 4'd8, 4'd13, 4'd0), 0, 6);
        run_queue("after_clear");

        // HALT then 20 idle cycles, then a clear pulse restarts fetch
        gen_instr(32'hD8000000, 1, 6);
        for (int i = 0; i < 20; i++) push(PH_HALTED, $urandom, 1'($urandom_range(0, 1)), 32'h0);
        run_queue("halt");
        @(negedge clock);
        clear = 1'b0;
        #1;
        check_outs(zero_o, PH_RST, "halt_clear");
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_outs(zero_o, PH_RST, "halt_release");
        gen_instr(mk(5'b01110, 4'd0, 4'd3, 4'd4), 0, 6);
        run_queue("refetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
